// File: rtl/vector_alu_seq.sv
// Multi-cycle vector ALU: 16 signed 32-bit lanes, LANES lanes per EXEC cycle,
// followed by a single-cycle write-back onto the register file's two write ports.
module vector_alu_seq #(
    parameter int LANES = 4,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [16*DW-1:0] opA,
    input  logic [16*DW-1:0] opB,
    input  logic [1:0]       dst1,
    input  logic [1:0]       dst2,
    output logic             busy,
    output logic             done,
    output logic [16*DW-1:0] result1,
    output logic [16*DW-1:0] result2,
    output logic [1:0]       wAdd1,
    output logic [1:0]       wAdd2,
    output logic             wEnable1,
    output logic             wEnable2,
    output logic [1:0]       state_dbg
);
    localparam int         NLANE = 16;
    localparam int         STEPS = NLANE / LANES;
    localparam logic [3:0] LAST  = 4'(STEPS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    logic [1:0]          state;
    logic [3:0]          cnt;
    logic [1:0]          op_q;
    logic [16*DW-1:0]    a_q;
    logic [16*DW-1:0]    b_q;
    logic [3:0]          lane_idx [LANES];
    logic [DW-1:0]       lo_v     [LANES];
    logic [DW-1:0]       hi_v     [LANES];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] prod;
        logic [DW-1:0]   lo;
        logic [DW-1:0]   hi;

        assign lane_idx[j] = 4'(int'(cnt) * LANES + j);
        assign a    = a_q[lane_idx[j]*DW +: DW];
        assign b    = b_q[lane_idx[j]*DW +: DW];
        // Sign-extend to full width first so the product is the exact signed 64-bit value.
        assign prod = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});

        always_comb begin
            lo = a + b;
            hi = '0;
            case (op_q)
                OP_ADD: lo = a + b;
                OP_SUB: lo = a - b;
                OP_MUL: begin
                    lo = prod[DW-1:0];
                    hi = prod[2*DW-1:DW];
                end
                OP_AND: lo = a & b;
                default: lo = a + b;
            endcase
        end

        assign lo_v[j] = lo;
        assign hi_v[j] = hi;
    end

    // start is the request valid and ~busy the ready: a request is taken on a rising
    // edge where start is high in IDLE; a start seen while busy is dropped, not queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            result1 <= '0;
            result2 <= '0;
            wAdd1   <= '0;
            wAdd2   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= opA;
                        b_q     <= opB;
                        op_q    <= op;
                        wAdd1   <= dst1;
                        wAdd2   <= dst2;
                        result1 <= '0;
                        result2 <= '0;
                        cnt     <= '0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    for (int j = 0; j < LANES; j++) begin
                        result1[lane_idx[j]*DW +: DW] <= lo_v[j];
                        result2[lane_idx[j]*DW +: DW] <= hi_v[j];
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    assign busy      = (state != IDLE);
    assign done      = (state == WRITE);
    assign wEnable1  = done;
    assign wEnable2  = done && (op_q == OP_MUL) && (wAdd1 != wAdd2);
    assign state_dbg = state;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Bench for vector_alu_seq: three instances (LANES = 1, 4, 16) share one stimulus
// stream and are checked against a lane-level arithmetic reference model.
module tb_vector_alu_seq;
    localparam int NI = 3;
    localparam int LN [NI] = '{1, 4, 16};
    localparam int WIN = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [511:0] opA;
    logic [511:0] opB;
    logic [1:0]   dst1;
    logic [1:0]   dst2;

    logic         busy_v  [NI];
    logic         done_v  [NI];
    logic [511:0] r1_v    [NI];
    logic [511:0] r2_v    [NI];
    logic [1:0]   wa1_v   [NI];
    logic [1:0]   wa2_v   [NI];
    logic         we1_v   [NI];
    logic         we2_v   [NI];
    logic [1:0]   st_v    [NI];

    int           n_vec = 0;
    int           n_err = 0;

    int           first_done  [NI];
    int           second_done [NI];
    int           ndone       [NI];
    int           nbusy       [NI];
    int           nstray      [NI];
    logic [511:0] cap_r1      [NI];
    logic [511:0] cap_r2      [NI];
    logic         cap_we1     [NI];
    logic         cap_we2     [NI];
    logic [1:0]   cap_wa1     [NI];
    logic [1:0]   cap_wa2     [NI];

    always #5 clk = ~clk;

    vector_alu_seq #(.LANES(1)) u_l1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .dst1(dst1), .dst2(dst2), .busy(busy_v[0]), .done(done_v[0]),
        .result1(r1_v[0]), .result2(r2_v[0]), .wAdd1(wa1_v[0]), .wAdd2(wa2_v[0]),
        .wEnable1(we1_v[0]), .wEnable2(we2_v[0]), .state_dbg(st_v[0])
    );
    vector_alu_seq #(.LANES(4)) u_l4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .dst1(dst1), .dst2(dst2), .busy(busy_v[1]), .done(done_v[1]),
        .result1(r1_v[1]), .result2(r2_v[1]), .wAdd1(wa1_v[1]), .wAdd2(wa2_v[1]),
        .wEnable1(we1_v[1]), .wEnable2(we2_v[1]), .state_dbg(st_v[1])
    );
    vector_alu_seq #(.LANES(16)) u_l16 (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .dst1(dst1), .dst2(dst2), .busy(busy_v[2]), .done(done_v[2]),
        .result1(r1_v[2]), .result2(r2_v[2]), .wAdd1(wa1_v[2]), .wAdd2(wa2_v[2]),
        .wEnable1(we1_v[2]), .wEnable2(we2_v[2]), .state_dbg(st_v[2])
    );

    // Reference model: whole-vector lane arithmetic on signed integers.
    function automatic void model(input logic [1:0] o, input logic [511:0] a, input logic [511:0] b,
                                  output logic [511:0] e1, output logic [511:0] e2);
        e1 = '0;
        e2 = '0;
        for (int k = 0; k < 16; k++) begin
            int    sa;
            int    sb;
            longint p;
            sa = int'(a[k*32 +: 32]);
            sb = int'(b[k*32 +: 32]);
            p  = longint'(sa) * longint'(sb);
            case (o)
                2'd0: e1[k*32 +: 32] = sa + sb;
                2'd1: e1[k*32 +: 32] = sa - sb;
                2'd2: begin
                    e1[k*32 +: 32] = p[31:0];
                    e2[k*32 +: 32] = p[63:32];
                end
                default: e1[k*32 +: 32] = a[k*32 +: 32] & b[k*32 +: 32];
            endcase
        end
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 5))
                0: v[k*32 +: 32] = 32'h8000_0000;
                1: v[k*32 +: 32] = 32'h7FFF_FFFF;
                2: v[k*32 +: 32] = 32'hFFFF_FFFF;
                3: v[k*32 +: 32] = 32'h0000_0000;
                default: v[k*32 +: 32] = $urandom();
            endcase
        end
        return v;
    endfunction

    // Called at a falling edge with every instance idle; returns 1 ns after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [511:0] a, input logic [511:0] b,
                         input logic [1:0] d1, input logic [1:0] d2, input bit hold);
        op    = o;
        opA   = a;
        opB   = b;
        dst1  = d1;
        dst2  = d2;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start = 1'b0;
            op    = 2'($urandom());
            opA   = rnd512();
            opB   = rnd512();
            dst1  = 2'($urandom());
            dst2  = 2'($urandom());
        end
    endtask

    // Samples every instance on falling edges; cycle c is the cycle after accept edge + c - 1.
    task automatic capture(input int ncyc);
        for (int i = 0; i < NI; i++) begin
            first_done[i]  = -1;
            second_done[i] = -1;
            ndone[i]       = 0;
            nbusy[i]       = 0;
            nstray[i]      = 0;
            cap_r1[i]      = 'x;
            cap_r2[i]      = 'x;
            cap_we1[i]     = 1'bx;
            cap_we2[i]     = 1'bx;
            cap_wa1[i]     = 'x;
            cap_wa2[i]     = 'x;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (busy_v[i]) nbusy[i]++;
                if ((we1_v[i] || we2_v[i]) && !done_v[i]) nstray[i]++;
                if (done_v[i]) begin
                    ndone[i]++;
                    if (first_done[i] < 0) first_done[i] = c;
                    else if (second_done[i] < 0) second_done[i] = c;
                    cap_r1[i]  = r1_v[i];
                    cap_r2[i]  = r2_v[i];
                    cap_we1[i] = we1_v[i];
                    cap_we2[i] = we2_v[i];
                    cap_wa1[i] = wa1_v[i];
                    cap_wa2[i] = wa2_v[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        op    = 2'($urandom());
        opA   = rnd512();
        opB   = rnd512();
        dst1  = 2'($urandom());
        dst2  = 2'($urandom());
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || we1_v[i] !== 1'b0 || we2_v[i] !== 1'b0 ||
                r1_v[i] !== '0 || r2_v[i] !== '0 || wa1_v[i] !== 2'd0 || wa2_v[i] !== 2'd0 || st_v[i] !== 2'd0) begin
                n_err++;
                $display("FAIL reset_state L%0d: busy=%b done=%b we=%b%b wa=%0d/%0d st=%0d r1nz=%b r2nz=%b, want all 0",
                         LN[i], busy_v[i], done_v[i], we1_v[i], we2_v[i], wa1_v[i], wa2_v[i], st_v[i],
                         |r1_v[i], |r2_v[i]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_add();
        logic [511:0] a, b, e1;
        for (int k = 0; k < 16; k++) begin
            a[k*32 +: 32]  = 32'd7;
            b[k*32 +: 32]  = -32'sd3;
            e1[k*32 +: 32] = 32'd4;
        end
        issue(2'b00, a, b, 2'd2, 2'd1, 1'b0);
        capture(WIN);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (first_done[i] !== 16/LN[i]+1 || ndone[i] !== 1 || nbusy[i] !== 16/LN[i]+1 || nstray[i] !== 0) begin
                n_err++;
                $display("FAIL add_timing L%0d: done@%0d x%0d busy=%0d stray=%0d, want done@%0d x1 busy=%0d stray=0",
                         LN[i], first_done[i], ndone[i], nbusy[i], nstray[i], 16/LN[i]+1, 16/LN[i]+1);
            end
            n_vec++;
            if (cap_r1[i] !== e1) begin
                n_err++;
                $display("FAIL add_result1 L%0d: got %h want %h", LN[i], cap_r1[i], e1);
            end
            n_vec++;
            if (cap_we1[i] !== 1'b1 || cap_we2[i] !== 1'b0 || cap_wa1[i] !== 2'd2 || cap_r2[i] !== '0) begin
                n_err++;
                $display("FAIL add_wb L%0d: we1=%b we2=%b wa1=%0d r2nz=%b, want we1=1 we2=0 wa1=2 r2=0",
                         LN[i], cap_we1[i], cap_we2[i], cap_wa1[i], |cap_r2[i]);
            end
            n_vec++;
            if (r1_v[i] !== e1 || wa1_v[i] !== 2'd2 || busy_v[i] !== 1'b0) begin
                n_err++;
                $display("FAIL add_hold L%0d: wa1=%0d busy=%b r1_ok=%b, want wa1=2 busy=0 r1_ok=1",
                         LN[i], wa1_v[i], busy_v[i], r1_v[i] === e1);
            end
        end
    endtask

    task automatic test_sub_wrap();
        logic [511:0] a, b, e1;
        for (int k = 0; k < 16; k++) begin
            a[k*32 +: 32]  = 32'h8000_0000;
            b[k*32 +: 32]  = 32'd1;
            e1[k*32 +: 32] = 32'h7FFF_FFFF;
        end
        issue(2'b01, a, b, 2'd3, 2'd0, 1'b0);
        capture(WIN);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (cap_r1[i] !== e1) begin
                n_err++;
                $display("FAIL sub_result1 L%0d: got %h want %h", LN[i], cap_r1[i], e1);
            end
            n_vec++;
            if (ndone[i] !== 1 || nstray[i] !== 0 || cap_we2[i] !== 1'b0 || cap_wa1[i] !== 2'd3 || cap_r2[i] !== '0) begin
                n_err++;
                $display("FAIL sub_side L%0d: ndone=%0d stray=%0d we2=%b wa1=%0d r2nz=%b, want 1 0 0 3 0",
                         LN[i], ndone[i], nstray[i], cap_we2[i], cap_wa1[i], |cap_r2[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [511:0] a, b, e1, e2;
        logic [1:0]   d1, d2;
        logic         exp_we2;
        a = '0;
        b = '0;
        e1 = '0;
        e2 = '0;
        a[31:0]     = 32'hFFFF_FFFE;
        b[31:0]     = 32'h4000_0000;
        e1[31:0]    = 32'h8000_0000;
        e2[31:0]    = 32'hFFFF_FFFF;
        a[511:480]  = 32'h7FFF_FFFF;
        b[511:480]  = 32'h7FFF_FFFF;
        e1[511:480] = 32'h0000_0001;
        e2[511:480] = 32'h3FFF_FFFF;
        for (int s = 0; s < 2; s++) begin
            d1      = (s == 0) ? 2'd0 : 2'd3;
            d2      = (s == 0) ? 2'd1 : 2'd3;
            exp_we2 = (s == 0);
            issue(2'b10, a, b, d1, d2, 1'b0);
            capture(WIN);
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if (cap_r1[i] !== e1) begin
                    n_err++;
                    $display("FAIL mul_result1 L%0d s%0d: got %h want %h", LN[i], s, cap_r1[i], e1);
                end
                n_vec++;
                if (cap_r2[i] !== e2) begin
                    n_err++;
                    $display("FAIL mul_result2 L%0d s%0d: got %h want %h", LN[i], s, cap_r2[i], e2);
                end
                n_vec++;
                if (ndone[i] !== 1 || cap_we1[i] !== 1'b1 || cap_we2[i] !== exp_we2 ||
                    cap_wa1[i] !== d1 || cap_wa2[i] !== d2) begin
                    n_err++;
                    $display("FAIL mul_wb L%0d s%0d: ndone=%0d we=%b%b wa=%0d/%0d, want 1 we=1%b wa=%0d/%0d",
                             LN[i], s, ndone[i], cap_we1[i], cap_we2[i], cap_wa1[i], cap_wa2[i], exp_we2, d1, d2);
                end
            end
        end
    endtask

    task automatic test_lane_order();
        logic [511:0] a, b, e1;
        for (int k = 0; k < 16; k++) begin
            a[k*32 +: 32]  = 32'(k);
            b[k*32 +: 32]  = 32'(16 * k);
            e1[k*32 +: 32] = 32'(17 * k);
        end
        issue(2'b00, a, b, 2'd1, 2'd2, 1'b0);
        capture(WIN);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (cap_r1[i] !== e1) begin
                n_err++;
                $display("FAIL lane_order L%0d: got %h want %h", LN[i], cap_r1[i], e1);
            end
            n_vec++;
            if (first_done[i] !== 16/LN[i]+1 || ndone[i] !== 1) begin
                n_err++;
                $display("FAIL lane_timing L%0d: done@%0d x%0d, want done@%0d x1",
                         LN[i], first_done[i], ndone[i], 16/LN[i]+1);
            end
        end
    endtask

    task automatic test_random();
        logic [511:0] a, b, e1, e2;
        logic [1:0]   o, d1, d2;
        logic         exp_we2;
        for (int t = 0; t < 12; t++) begin
            o  = 2'($urandom());
            a  = rnd512();
            b  = rnd512();
            d1 = 2'($urandom());
            d2 = 2'($urandom());
            model(o, a, b, e1, e2);
            exp_we2 = (o == 2'b10) && (d1 != d2);
            issue(o, a, b, d1, d2, 1'b0);
            capture(WIN);
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if (cap_r1[i] !== e1) begin
                    n_err++;
                    $display("FAIL rand_result1 L%0d t%0d op%0d: got %h want %h", LN[i], t, o, cap_r1[i], e1);
                end
                n_vec++;
                if (cap_r2[i] !== e2) begin
                    n_err++;
                    $display("FAIL rand_result2 L%0d t%0d op%0d: got %h want %h", LN[i], t, o, cap_r2[i], e2);
                end
                n_vec++;
                if (first_done[i] !== 16/LN[i]+1 || ndone[i] !== 1 || nstray[i] !== 0 ||
                    cap_we1[i] !== 1'b1 || cap_we2[i] !== exp_we2 || cap_wa1[i] !== d1 || cap_wa2[i] !== d2) begin
                    n_err++;
                    $display("FAIL rand_wb L%0d t%0d: done@%0d x%0d stray=%0d we=%b%b wa=%0d/%0d, want @%0d x1 0 we=1%b wa=%0d/%0d",
                             LN[i], t, first_done[i], ndone[i], nstray[i], cap_we1[i], cap_we2[i],
                             cap_wa1[i], cap_wa2[i], 16/LN[i]+1, exp_we2, d1, d2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] a, b, e1;
        int           f, p, exp_n, exp_second;
        for (int k = 0; k < 16; k++) begin
            a[k*32 +: 32]  = 32'hFFFF_FFFF;
            b[k*32 +: 32]  = 32'h0F0F_0F0F;
            e1[k*32 +: 32] = 32'h0F0F_0F0F;
        end
        issue(2'b11, a, b, 2'd0, 2'd0, 1'b1);
        capture(WIN);
        start = 1'b0;
        for (int i = 0; i < NI; i++) begin
            f     = 16 / LN[i] + 1;
            p     = 16 / LN[i] + 2;
            exp_n = 0;
            for (int t = f; t <= WIN; t += p) exp_n++;
            exp_second = (f + p <= WIN) ? f + p : -1;
            n_vec++;
            if (ndone[i] !== exp_n || first_done[i] !== f || second_done[i] !== exp_second || nstray[i] !== 0) begin
                n_err++;
                $display("FAIL b2b_timing L%0d: ndone=%0d first=%0d second=%0d stray=%0d, want %0d %0d %0d 0",
                         LN[i], ndone[i], first_done[i], second_done[i], nstray[i], exp_n, f, exp_second);
            end
            n_vec++;
            if (cap_r1[i] !== e1 || cap_we2[i] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_result L%0d: we2=%b got %h want %h", LN[i], cap_we2[i], cap_r1[i], e1);
            end
        end
        repeat (WIN) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [511:0] a, b, e1, e2;
        int           early_strobe [NI];
        a = rnd512();
        b = rnd512();
        for (int i = 0; i < NI; i++) early_strobe[i] = 0;
        issue(2'b10, a, b, 2'd1, 2'd2, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (done_v[i] || we1_v[i] || we2_v[i]) early_strobe[i]++;
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || we1_v[i] !== 1'b0 || we2_v[i] !== 1'b0 ||
                r1_v[i] !== '0 || r2_v[i] !== '0 || wa1_v[i] !== 2'd0 || wa2_v[i] !== 2'd0 || early_strobe[i] !== 0) begin
                n_err++;
                $display("FAIL midreset_zero L%0d: busy=%b done=%b we=%b%b wa=%0d/%0d early=%0d r1nz=%b r2nz=%b, want all 0",
                         LN[i], busy_v[i], done_v[i], we1_v[i], we2_v[i], wa1_v[i], wa2_v[i], early_strobe[i],
                         |r1_v[i], |r2_v[i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        capture(WIN);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (ndone[i] !== 0 || nbusy[i] !== 0 || nstray[i] !== 0) begin
                n_err++;
                $display("FAIL midreset_abort L%0d: ndone=%0d busy=%0d stray=%0d, want 0 0 0",
                         LN[i], ndone[i], nbusy[i], nstray[i]);
            end
        end
        a = rnd512();
        b = rnd512();
        model(2'b10, a, b, e1, e2);
        issue(2'b10, a, b, 2'd2, 2'd3, 1'b0);
        capture(WIN);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (cap_r1[i] !== e1 || cap_r2[i] !== e2) begin
                n_err++;
                $display("FAIL midreset_after L%0d: r1_ok=%b r2_ok=%b, want both 1",
                         LN[i], cap_r1[i] === e1, cap_r2[i] === e2);
            end
            n_vec++;
            if (ndone[i] !== 1 || cap_we1[i] !== 1'b1 || cap_we2[i] !== 1'b1 || cap_wa1[i] !== 2'd2 || cap_wa2[i] !== 2'd3) begin
                n_err++;
                $display("FAIL midreset_wb L%0d: ndone=%0d we=%b%b wa=%0d/%0d, want 1 we=11 wa=2/3",
                         LN[i], ndone[i], cap_we1[i], cap_we2[i], cap_wa1[i], cap_wa2[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_add();
        test_sub_wrap();
        test_mul();
        test_lane_order();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
